ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch front end; the consumer side of the program-counter interface.
- Holds the architectural fetch PC and issues word-aligned reads to instruction memory over a req/gnt/rvalid handshake, with at most one read outstanding.
- Buffers returned words with their PCs in a small queue and presents them to decode over valid/ready.
- A redirect from branch/jump resolution flushes the queue, drops any in-flight response and restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- QDEPTH, 2, instruction queue entries (power of 2, 2..8).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  read request, registered.
- imem_addr  out  32  read address; bits [1:0] always 0.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid, one cycle per granted request, 1+ cycles after gnt.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  single-cycle fetch restart.
- redirect_pc  in  32  restart target; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode consumes head.
- inst_data  out  32  head instruction.
- inst_pc  out  32  head PC.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (edge with rst=1): fetch_pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, queue count=0, inst_valid=0, inst_data=0, inst_pc=0, drop=0. Reset overrides redirect and all handshakes, including mid-transaction: a response arriving after reset is ignored because no request is outstanding.
- States:
  - IDLE: no request.
  - REQ: imem_req=1, imem_addr=fetch_pc.
  - RSP: granted, awaiting rvalid.
- Space condition: space = (count + pending) < QDEPTH, where pending = 1 in RSP with drop=0, else 0.
- IDLE -> REQ when space and no redirect this cycle.
- REQ rules:
  - imem_req and imem_addr are held stable until imem_gnt; a request is never withdrawn.
  - On gnt: fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), go to RSP.
- RSP rules:
  - On imem_rvalid with drop=0: enqueue {fetch addr, imem_rdata}.
  - On imem_rvalid with drop=1: discard the data and clear drop.
  - Next state is REQ if space after this cycle's enqueue/dequeue and no redirect, else IDLE. Back-to-back issue is therefore allowed: new req visible the cycle after rvalid.
- imem_rvalid in IDLE or REQ is ignored.
- Queue:
  - FIFO with wrap-around pointers.
  - inst_valid = (count != 0); inst_data and inst_pc come from the head.
  - Dequeue when inst_valid && inst_ready.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Latency rvalid -> inst_valid is 1 cycle (registered, no bypass).
  - The queue never overflows, by the space rule.
- Redirect (highest priority after rst):
  - Queue is flushed (count=0, inst_valid=0 next cycle); a dequeue in the same cycle is a don't-care.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - In RSP, or in REQ with gnt this cycle: drop<=1 and state RSP. The stale response is discarded; the next request is issued after it returns.
  - In REQ without gnt: the request stays up with its old address until granted, then drop<=1; fetch_pc already holds the new target.
  - In IDLE: state goes to REQ next cycle.
  - Redirect in the same cycle as rvalid: that rvalid data is discarded and drop is not set.
- No instruction fetched before a redirect ever appears on inst_* after the redirect cycle.

Test Plan:
- Reset then zero-latency memory (gnt=1 immediately, rvalid 1 cycle after gnt) with inst_ready=1 and data = address^32'hA5A5_0000 -> inst_pc sequence 0,4,8,C; first inst_valid within 4 cycles of rst low; inst_data matches.
- inst_ready=0 for 10 cycles -> exactly QDEPTH(2) entries held (pc 0,4); imem_req low once full; on release, next req addr=8 and order is preserved.
- imem_gnt withheld 5 cycles -> imem_req and imem_addr stable throughout; exactly one rvalid consumed per gnt.
- Redirect to 32'h0000_1003 while in RSP for addr 8 -> stale word for 8 dropped, queue flushed, next req addr 32'h0000_1000, first inst_pc 32'h0000_1000.
- Redirect during REQ without gnt (addr C) -> req held at C until gnt, response dropped, next req 32'h0000_2000.
- Wrap: redirect to 32'hFFFF_FFF8 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted in RSP, with rvalid arriving the next cycle -> outputs at reset values and rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bundle: instruction-memory handshake, redirect input and decode-side
// instruction stream.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: one outstanding word read, small instruction queue,
// and redirect handling that flushes the queue and drops stale responses.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input logic           clk,
    input logic           rst,
    ifetch_unit_if.master bus
);
    localparam int unsigned   PtrW   = $clog2(QDEPTH);
    localparam logic [PtrW:0] DepthC = (PtrW + 1)'(QDEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e          state_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     imem_addr_q;
    logic            imem_req_q;
    logic            drop_q;
    logic            redir_pend_q;
    logic [PtrW:0]   count_q;
    logic [PtrW-1:0] rptr_q;
    logic [PtrW-1:0] wptr_q;
    logic [31:0]     q_data_q [QDEPTH];
    logic [31:0]     q_pc_q   [QDEPTH];

    logic [31:0]   target;
    logic          enq;
    logic          deq;
    logic          pending;
    logic          space;
    logic          space_after;
    logic [PtrW:0] cnt_after;
    logic [PtrW+1:0] occ;

    always_comb begin
        target      = {bus.redirect_pc[31:2], 2'b00};
        enq         = (state_q == StRsp) && bus.imem_rvalid && !drop_q && !bus.redirect_valid;
        deq         = (count_q != '0) && bus.inst_ready;
        pending     = (state_q == StRsp) && !drop_q;
        occ         = {1'b0, count_q} + {{(PtrW + 1){1'b0}}, pending};
        space       = occ < {1'b0, DepthC};
        cnt_after   = count_q + {{PtrW{1'b0}}, enq} - {{PtrW{1'b0}}, deq};
        space_after = cnt_after < DepthC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            imem_addr_q  <= RESET_PC;
            imem_req_q   <= 1'b0;
            drop_q       <= 1'b0;
            redir_pend_q <= 1'b0;
            count_q      <= '0;
            rptr_q       <= '0;
            wptr_q       <= '0;
            q_data_q     <= '{default: '0};
            q_pc_q       <= '{default: '0};
        end else begin
            if (bus.redirect_valid) begin
                count_q <= '0;
                rptr_q  <= '0;
                wptr_q  <= '0;
            end else begin
                if (enq) begin
                    q_data_q[wptr_q] <= bus.imem_rdata;
                    q_pc_q[wptr_q]   <= imem_addr_q;
                    wptr_q           <= wptr_q + PtrW'(1);
                end
                if (deq) rptr_q <= rptr_q + PtrW'(1);
                count_q <= cnt_after;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.redirect_valid) fetch_pc_q <= target;
                    if (bus.redirect_valid || space) begin
                        state_q     <= StReq;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= bus.redirect_valid ? target : fetch_pc_q;
                    end
                end
                StReq: begin
                    if (bus.imem_gnt) begin
                        state_q      <= StRsp;
                        imem_req_q   <= 1'b0;
                        redir_pend_q <= 1'b0;
                        if (bus.redirect_valid) begin
                            fetch_pc_q <= target;
                            drop_q     <= 1'b1;
                        end else if (redir_pend_q) begin
                            // fetch_pc already holds the redirect target; this grant is stale
                            drop_q <= 1'b1;
                        end else begin
                            fetch_pc_q <= fetch_pc_q + 32'd4;
                        end
                    end else if (bus.redirect_valid) begin
                        // Request stays up at its old address; remember to drop its data
                        fetch_pc_q   <= target;
                        redir_pend_q <= 1'b1;
                    end
                end
                StRsp: begin
                    if (bus.redirect_valid) fetch_pc_q <= target;
                    if (bus.imem_rvalid) begin
                        drop_q <= 1'b0;
                        if (bus.redirect_valid || space_after) begin
                            state_q     <= StReq;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= bus.redirect_valid ? target : fetch_pc_q;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (bus.redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst_data  = q_data_q[rptr_q];
    assign bus.inst_pc    = q_pc_q[rptr_q];
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: behavioural instruction memory plus a queue of expected
// (pc, data) pairs checked whenever decode consumes an instruction.
module tb_ifetch_unit;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC(32'h0000_0000),
        .QDEPTH  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] target;
        int          gdly;
        int          lat;
        int          n;
        logic [31:0] first;
    } vec_t;

    vec_t vecs [5];

    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;
    logic [31:0] exp_q [$];

    int          gnt_delay;
    int          rsp_lat;
    int          req_age;
    int          rsp_cnt;
    int          gnt_cnt;
    bit          rsp_busy;
    logic [31:0] rsp_addr;
    logic [31:0] last_gnt_addr;
    bit          hold_prev;
    logic [31:0] hold_addr;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Sampled on the falling edge; anything seen here is what the next rising edge acts on.
    task automatic monitor();
        logic [31:0] e;
        if (!rst && !bus.redirect_valid && bus.inst_valid === 1'b1 && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got pc %h, expected no instruction", bus.inst_pc);
            end else begin
                e = exp_q.pop_front();
                check32("inst_pc", bus.inst_pc, e);
                check32("inst_data", bus.inst_data, e ^ K);
            end
            pop_cnt++;
        end
        if (bus.imem_req === 1'b1) check32("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
        hold_prev = (bus.imem_req === 1'b1) && !bus.imem_gnt && !rst;
        hold_addr = bus.imem_addr;
    endtask

    task automatic mem_model();
        if (hold_prev) begin
            check32("req_held", {31'd0, bus.imem_req}, 32'd1);
            check32("addr_held", bus.imem_addr, hold_addr);
        end
        bus.imem_rvalid = 1'b0;
        if (rsp_busy) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = rsp_addr ^ K;
                rsp_busy        = 1'b0;
            end
        end
        bus.imem_gnt = 1'b0;
        if (bus.imem_req === 1'b1 && !rsp_busy && req_age >= gnt_delay) begin
            bus.imem_gnt  = 1'b1;
            rsp_busy      = 1'b1;
            rsp_cnt       = rsp_lat;
            rsp_addr      = bus.imem_addr;
            last_gnt_addr = bus.imem_addr;
            gnt_cnt++;
            req_age = 0;
        end else if (bus.imem_req === 1'b1) begin
            req_age++;
        end else begin
            req_age = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        mem_model();
    endtask

    task automatic push_seq(input logic [31:0] first, input int n);
        logic [31:0] p;
        p = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        exp_q.delete();
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int start;
        int k;
        start = pop_cnt;
        k = 0;
        while (pop_cnt - start < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (pop_cnt - start < n) begin
            errors++;
            $display("FAIL %s: got %0d instructions, expected %0d", name, pop_cnt - start, n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  g0;
        bit  found;

        vecs[0] = '{target: 32'h0000_0040, gdly: 0, lat: 1, n: 3, first: 32'h0000_0040};
        vecs[1] = '{target: 32'h0000_0103, gdly: 2, lat: 1, n: 3, first: 32'h0000_0100};
        vecs[2] = '{target: 32'h0000_0202, gdly: 0, lat: 3, n: 3, first: 32'h0000_0200};
        vecs[3] = '{target: 32'hFFFF_FFF8, gdly: 0, lat: 1, n: 3, first: 32'hFFFF_FFF8};
        vecs[4] = '{target: 32'h8000_0001, gdly: 1, lat: 2, n: 4, first: 32'h8000_0000};

        rst = 1'b1;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.inst_ready = 1'b0;
        gnt_delay = 0;
        rsp_lat = 1;
        req_age = 0;
        rsp_cnt = 0;
        gnt_cnt = 0;
        rsp_busy = 1'b0;
        rsp_addr = 32'd0;
        last_gnt_addr = 32'hFFFF_FFFF;
        hold_prev = 1'b0;
        hold_addr = 32'd0;

        repeat (3) tick();
        check32("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check32("rst_addr", bus.imem_addr, 32'd0);
        check32("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check32("rst_data", bus.inst_data, 32'd0);
        check32("rst_pc", bus.inst_pc, 32'd0);

        // Zero-latency stream from reset
        bus.inst_ready = 1'b1;
        rst = 1'b0;
        push_seq(32'h0, 16);
        found = 1'b0;
        for (int i = 1; i <= 4 && !found; i++) begin
            tick();
            if (bus.inst_valid === 1'b1) found = 1'b1;
        end
        check32("first_valid_within_4", {31'd0, found}, 32'd1);
        wait_pops(4, 50, "stream");

        // Back-pressure: queue fills to two entries and fetch stops
        bus.inst_ready = 1'b0;
        do_redirect(32'h0);
        push_seq(32'h0, 16);
        repeat (10) tick();
        check32("bp_req_low", {31'd0, bus.imem_req}, 32'd0);
        check32("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
        check32("bp_head_pc", bus.inst_pc, 32'h0);
        check32("bp_last_gnt", last_gnt_addr, 32'h4);
        bus.inst_ready = 1'b1;
        g0 = gnt_cnt;
        k = 0;
        while (gnt_cnt == g0 && k < 20) begin
            tick();
            k++;
        end
        check32("bp_next_addr", last_gnt_addr, 32'h8);
        wait_pops(4, 60, "bp_release");

        // Grant withheld for five cycles on every request
        gnt_delay = 5;
        do_redirect(32'h300);
        push_seq(32'h300, 16);
        wait_pops(3, 120, "gnt_stall");

        // Redirect while the response for address 8 is outstanding
        gnt_delay = 0;
        rsp_lat = 3;
        do_redirect(32'h0);
        push_seq(32'h0, 16);
        k = 0;
        while (!(bus.imem_gnt && bus.imem_addr == 32'h8) && k < 60) begin
            tick();
            k++;
        end
        check32("rsp8_gnt_addr", bus.imem_gnt ? bus.imem_addr : 32'hFFFF_FFFF, 32'h8);
        tick();
        do_redirect(32'h0000_1003);
        push_seq(32'h0000_1000, 16);
        g0 = gnt_cnt;
        k = 0;
        while (gnt_cnt == g0 && k < 30) begin
            tick();
            k++;
        end
        check32("rsp8_next_addr", last_gnt_addr, 32'h0000_1000);
        wait_pops(2, 60, "rsp8_restart");

        // Redirect while a request for address C waits for its grant
        gnt_delay = 3;
        rsp_lat = 1;
        do_redirect(32'h0);
        push_seq(32'h0, 16);
        k = 0;
        while (!(bus.imem_req && bus.imem_addr == 32'hC && !bus.imem_gnt) && k < 60) begin
            tick();
            k++;
        end
        check32("reqc_addr", bus.imem_req ? bus.imem_addr : 32'hFFFF_FFFF, 32'hC);
        do_redirect(32'h0000_2000);
        push_seq(32'h0000_2000, 16);
        check32("reqc_held_req", {31'd0, bus.imem_req}, 32'd1);
        check32("reqc_held_addr", bus.imem_addr, 32'hC);
        k = 0;
        while (!(bus.imem_req && bus.imem_addr != 32'hC) && k < 40) begin
            tick();
            k++;
        end
        check32("reqc_next_addr", bus.imem_req ? bus.imem_addr : 32'hFFFF_FFFF, 32'h0000_2000);
        wait_pops(2, 80, "reqc_restart");

        // Reset while a response is outstanding; it returns the cycle after reset
        gnt_delay = 0;
        rsp_lat = 2;
        do_redirect(32'h40);
        push_seq(32'h40, 16);
        k = 0;
        while (!bus.imem_gnt && k < 20) begin
            tick();
            k++;
        end
        check32("rstrsp_gnt", {31'd0, bus.imem_gnt}, 32'd1);
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        check32("rstrsp_rvalid_now", {31'd0, bus.imem_rvalid}, 32'd1);
        check32("rstrsp_req", {31'd0, bus.imem_req}, 32'd0);
        check32("rstrsp_addr", bus.imem_addr, 32'd0);
        check32("rstrsp_valid", {31'd0, bus.inst_valid}, 32'd0);
        check32("rstrsp_pc", bus.inst_pc, 32'd0);
        check32("rstrsp_data", bus.inst_data, 32'd0);
        rst = 1'b0;
        push_seq(32'h0, 16);
        wait_pops(3, 60, "rstrsp_restart");

        // Table of redirect targets and memory timings, including address wrap
        for (int v = 0; v < 5; v++) begin
            gnt_delay = vecs[v].gdly;
            rsp_lat   = vecs[v].lat;
            do_redirect(vecs[v].target);
            push_seq(vecs[v].first, 16);
            wait_pops(vecs[v].n, 200, "vec");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
